// File: rtl/current_state_regfile.sv
// Displayed Game of Life generation: 2**REGBITS rows of WIDTH cells, one combinational
// read port and one synchronous write port. Define CURRENT_STATE_SEED_EN to reset to a glider.
module current_state_regfile #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic               ph2,
    input  logic               reset,
    input  logic               regwrite,
    input  logic [REGBITS-1:0] ra,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    output logic [WIDTH-1:0]   rd
);

    localparam int ROWS = 1 << REGBITS;

    logic [WIDTH-1:0] ram [ROWS];

    // Per-row reset image; only rows 0..2 can be non-zero, in bits [2:0].
    function automatic logic [WIDTH-1:0] reset_row(input int row);
        logic [WIDTH-1:0] v;
        v = '0;
`ifdef CURRENT_STATE_SEED_EN
        case (row)
            0:       v[2:0] = 3'b010;
            1:       v[2:0] = 3'b100;
            2:       v[2:0] = 3'b111;
            default: v = '0;
        endcase
`endif
        return v;
    endfunction

    // Write strobe: regwrite is sampled on the rising ph2 edge only while reset is released;
    // there is no ready/backpressure, every enabled edge commits wd into row wa.
    always_ff @(posedge ph2 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) begin
                ram[i] <= reset_row(i);
            end
        end else if (regwrite) begin
            ram[wa] <= wd;
        end
    end

    // No write bypass: a same-row write becomes visible only after the edge.
    assign rd = ram[ra];

endmodule

// File: tb/tb_current_state_regfile.sv
// Self-checking bench for current_state_regfile: row-array model, per-cycle compare,
// plus hand-computed literal checks for reset, write, hold, same-row timing and sweep.
module tb_current_state_regfile;

    localparam int WIDTH   = 8;
    localparam int REGBITS = 3;
    localparam int ROWS    = 1 << REGBITS;

    logic               ph2;
    logic               reset;
    logic               regwrite;
    logic [REGBITS-1:0] ra;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
    logic [WIDTH-1:0]   rd;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [WIDTH-1:0] model [ROWS];

    current_state_regfile #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
        .ph2      (ph2),
        .reset    (reset),
        .regwrite (regwrite),
        .ra       (ra),
        .wa       (wa),
        .wd       (wd),
        .rd       (rd)
    );

    // Clock and watchdog
    initial begin
        ph2 = 1'b0;
        forever #5 ph2 = ~ph2;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [WIDTH-1:0] rst_val(input int row);
`ifdef CURRENT_STATE_SEED_EN
        case (row)
            0:       return 8'h02;
            1:       return 8'h04;
            2:       return 8'h07;
            default: return 8'h00;
        endcase
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ROWS; i++) model[i] = rst_val(i);
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: ra=%0d got %h expected %h at %0t", name, ra, act, exp, $time);
        end
    endtask

    // One row cycle: drive row address/data, let one rising edge pass, update the model.
    task automatic row_cycle(input bit we, input int a, input logic [WIDTH-1:0] d);
        bit took;
        regwrite = we;
        ra = REGBITS'(a);
        wa = REGBITS'(a);
        wd = d;
        @(posedge ph2);
        took = we && (reset === 1'b1);
        #1;
        if (took) model[a] = d;
    endtask

    // Per-cycle compare of the read port against the model
    always @(negedge ph2) begin
        if (cmp_en) check("cycle_read", rd, model[ra]);
    end

    initial begin
        reset = 1'b0;
        regwrite = 1'b0;
        ra = '0;
        wa = '0;
        wd = '0;
        model_reset();
        repeat (3) @(posedge ph2);
        #1;

        // Reset state of every row, pinned by literal for row 0 and row 3
        for (int i = 0; i < ROWS; i++) begin
            ra = REGBITS'(i);
            #1;
            check("reset_row", rd, rst_val(i));
        end
        ra = 3'd0;
        #1;
`ifdef CURRENT_STATE_SEED_EN
        check("reset_lit_row0", rd, 8'h02);
`else
        check("reset_lit_row0", rd, 8'h00);
`endif
        ra = 3'd3;
        #1;
        check("reset_lit_row3", rd, 8'h00);

        // Release reset and write on the very first edge with reset high
        reset = 1'b1;
        cmp_en = 1'b1;
        row_cycle(1'b1, 5, 8'hA5);
        check("write_row5", rd, 8'hA5);
        for (int i = 0; i < ROWS; i++) row_cycle(1'b0, i, 8'h00);
        ra = 3'd4;
        #1;
        check("neighbour_row4", rd, rst_val(4));

        // Write disabled keeps the prior value of row 3
        row_cycle(1'b1, 3, 8'h33);
        repeat (4) row_cycle(1'b0, 3, 8'hFF);
        check("hold_row3", rd, 8'h33);

        // Same-address read during write: old value until the edge, new value after
        regwrite = 1'b1;
        ra = 3'd2;
        wa = 3'd2;
        wd = 8'h3C;
        #2;
        check("raw_before_edge", rd, rst_val(2));
        @(posedge ph2);
        #1;
        model[2] = 8'h3C;
        check("raw_after_edge", rd, 8'h3C);
        regwrite = 1'b0;

        // Full sweep and readback, including the wrap from 7 to 0
        for (int i = 0; i < ROWS; i++) row_cycle(1'b1, i, 8'h01 << i);
        for (int i = 0; i < ROWS; i++) row_cycle(1'b0, i, 8'h00);
        ra = 3'd7;
        #1;
        check("sweep_row7", rd, 8'h80);
        ra = 3'd0;
        #1;
        check("sweep_wrap_row0", rd, 8'h01);
        ra = 3'd6;
        #1;
        check("sweep_row6", rd, 8'h40);

        // Asynchronous reset mid-sweep, away from any clock edge
        for (int i = 0; i < 4; i++) row_cycle(1'b1, i, 8'h80 >> i);
        regwrite = 1'b1;
        wa = 3'd1;
        wd = 8'hFF;
        #2;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < ROWS; i++) begin
            ra = REGBITS'(i);
            #0.5;
            check("async_reset", rd, rst_val(i));
        end
        // Writes are ignored while reset is held across an edge
        row_cycle(1'b1, 1, 8'hFF);
        check("write_in_reset", rd, rst_val(1));

        reset = 1'b1;
        row_cycle(1'b1, 7, 8'h5A);
        check("post_reset_write", rd, 8'h5A);
        for (int i = 0; i < ROWS; i++) row_cycle(1'b0, 7 - i, 8'h00);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
